// File: rtl/mul_arbiter.sv
// Two-port round-robin arbiter and multicycle controller for a shared combinational multiplier.
// Optional MUL_ARB_ZERO_BYPASS_EN: a zero operand skips the multicycle wait and returns 0 at once.
//
// state | meaning
// IDLE  | waiting for a request; grant and operand capture happen here
// RUN   | operands held on mul_a/mul_b while the latency counter runs down
// DONE  | product held on the response channel until resp_ready
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_result,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    input  logic             resp_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             rr;
    logic [1:0]       grant;
    logic             gnt_id;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             zero_op;

    // Single requester wins outright; on contention rr picks the preferred port.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign gnt_id = grant[1];
    assign sel_a  = gnt_id ? req_a1 : req_a0;
    assign sel_b  = gnt_id ? req_b1 : req_b0;

`ifdef MUL_ARB_ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant != 2'b00) state_nx = zero_op ? DONE : RUN;
            RUN:     if (cnt == '0) state_nx = DONE;
            DONE:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a       <= '0;
            mul_b       <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            cnt         <= '0;
            rr          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        mul_a   <= sel_a;
                        mul_b   <= sel_b;
                        resp_id <= gnt_id;
                        cnt     <= CW'(LATENCY - 1);
                        if (zero_op) resp_result <= '0;
                    end
                end
                RUN: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           resp_result <= mul_result;
                end
                DONE: begin
                    if (resp_ready) rr <= ~resp_id;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE) ? grant : 2'b00;
        busy       = (state != IDLE);
        resp_valid = (state == DONE);
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: scoreboard of expected products, one task per scenario.
module tb_mul_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]  req_ready;
    logic [31:0] mul_a, mul_b, mul_result, resp_result;
    logic        resp_valid, resp_id, busy;
    logic        resp_ready = 1'b0;

    logic [1:0]  l_req_valid = 2'b00;
    logic [31:0] l_a0 = '0, l_b0 = '0;
    logic [1:0]  l_req_ready;
    logic [31:0] l_mul_a, l_mul_b, l_mul_result, l_resp_result;
    logic        l_resp_valid, l_resp_id, l_busy;
    logic        l_resp_ready = 1'b0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side model of the shared multiplier: low 32 bits of the product.
    assign mul_result   = mul_a * mul_b;
    assign l_mul_result = l_mul_a * l_mul_b;

    mul_arbiter #(.WIDTH(32), .LATENCY(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_ready(resp_ready), .busy(busy)
    );

    mul_arbiter #(.WIDTH(32), .LATENCY(1), .CW(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(l_req_valid), .req_ready(l_req_ready),
        .req_a0(l_a0), .req_b0(l_b0), .req_a1(32'd0), .req_b1(32'd0),
        .mul_a(l_mul_a), .mul_b(l_mul_b), .mul_result(l_mul_result),
        .resp_valid(l_resp_valid), .resp_id(l_resp_id), .resp_result(l_resp_result),
        .resp_ready(l_resp_ready), .busy(l_busy)
    );

    // Drive a request and wait for its handshake; pushes the expected result.
    task automatic issue(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         output logic [1:0] gnt, output int t, output bit to);
        exp_t e;
        @(negedge clk);
        req_valid = vld; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        #1;
        to = 1'b1; gnt = 2'b00; t = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready != 2'b00) begin
                gnt = req_ready; t = cyc; to = 1'b0;
                break;
            end
            @(negedge clk); #1;
        end
        if (!to) begin
            e.id  = gnt[1];
            e.res = gnt[1] ? a1 * b1 : a0 * b0;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    // Wait for the response, hold backpressure for 'hold' cycles, then take it.
    task automatic collect(input int hold, output logic id, output logic [31:0] res,
                           output int t, output bit to, output bit stable,
                           output int busy_cyc, output exp_t e);
        #1;
        to = 1'b1; t = 0; busy_cyc = 0; stable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (busy) busy_cyc++;
            if (resp_valid) begin
                to = 1'b0; t = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        id = resp_id; res = resp_result;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #1;
            if (!resp_valid || resp_id !== id || resp_result !== res || req_ready !== 2'b00)
                stable = 1'b0;
        end
        if (sbq.size() != 0) e = sbq.pop_front();
        else begin e.id = 1'bx; e.res = 'x; end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        n_cmp++; if (resp_id !== 1'b0) begin n_bad++; $display("FAIL reset_resp_id got=%b want=0", resp_id); end
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        n_cmp++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin n_bad++; $display("FAIL reset_mul_ab got=%h/%h want=0/0", mul_a, mul_b); end
        n_cmp++; if (resp_result !== 32'd0) begin n_bad++; $display("FAIL reset_resp_result got=%h want=0", resp_result); end
    endtask

    task automatic test_single();
        logic [1:0] gnt; int t0, t1, bc; bit to, st; logic id; logic [31:0] res; exp_t e;
        issue(2'b01, 32'd7, 32'd6, 32'd0, 32'd0, gnt, t0, to);
        n_cmp++; if (to || gnt !== 2'b01) begin n_bad++; $display("FAIL single_grant got=%b timeout=%0d want=01", gnt, to); end
        collect(0, id, res, t1, to, st, bc, e);
        n_cmp++; if (to) begin n_bad++; $display("FAIL single_resp_timeout got=timeout want=response"); end
        n_cmp++; if (t1 - t0 != 5) begin n_bad++; $display("FAIL single_latency got=%0d want=5", t1 - t0); end
        n_cmp++; if (id !== e.id || res !== e.res) begin n_bad++; $display("FAIL single_sb got=%b/%h want=%b/%h", id, res, e.id, e.res); end
        n_cmp++; if (res !== 32'h2A) begin n_bad++; $display("FAIL single_result got=%h want=2a", res); end
        n_cmp++; if (bc != 5) begin n_bad++; $display("FAIL single_busy_cycles got=%0d want=5", bc); end
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        logic [1:0] gnt; int t0, t1, bc; bit to, st; logic id; logic [31:0] res; exp_t e;
        issue(2'b10, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd5, gnt, t0, to);
        n_cmp++; if (to || gnt !== 2'b10) begin n_bad++; $display("FAIL bp_grant got=%b want=10", gnt); end
        req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd1;
        collect(3, id, res, t1, to, st, bc, e);
        req_valid = 2'b00;
        n_cmp++; if (to || id !== 1'b1 || res !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL bp_result got=%b/%h want=1/fffffff1", id, res); end
        n_cmp++; if (id !== e.id || res !== e.res) begin n_bad++; $display("FAIL bp_sb got=%b/%h want=%b/%h", id, res, e.id, e.res); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL bp_stable got=%b want=1", st); end
    endtask

    task automatic test_contention();
        logic [1:0] gnt, want; int t0, t1, bc; bit to, st; logic id; logic [31:0] res; exp_t e;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 1) ? 2'b10 : 2'b01;
            issue(2'b11, 32'd2, 32'd3, 32'd4, 32'd5, gnt, t0, to);
            n_cmp++; if (to || gnt !== want || !$onehot(gnt)) begin n_bad++; $display("FAIL cont_grant[%0d] got=%b want=%b", i, gnt, want); end
            collect(0, id, res, t1, to, st, bc, e);
            n_cmp++; if (to || id !== e.id || res !== e.res) begin n_bad++; $display("FAIL cont_sb[%0d] got=%b/%h want=%b/%h", i, id, res, e.id, e.res); end
            n_cmp++; if (res !== ((i % 2 == 1) ? 32'd20 : 32'd6)) begin n_bad++; $display("FAIL cont_result[%0d] got=%0d", i, res); end
        end
    endtask

    task automatic test_overflow();
        logic [1:0] gnt; int t0, t1, bc, zlat; bit to, st; logic id; logic [31:0] res; exp_t e;
        issue(2'b01, 32'h8000_0000, 32'd2, 32'd0, 32'd0, gnt, t0, to);
        collect(0, id, res, t1, to, st, bc, e);
        n_cmp++; if (to || res !== 32'd0 || res !== e.res) begin n_bad++; $display("FAIL ovf_result got=%h want=00000000", res); end
        n_cmp++; if (t1 - t0 != 5) begin n_bad++; $display("FAIL ovf_latency got=%0d want=5", t1 - t0); end
`ifdef MUL_ARB_ZERO_BYPASS_EN
        zlat = 1;
`else
        zlat = 5;
`endif
        issue(2'b01, 32'd0, 32'd9, 32'd0, 32'd0, gnt, t0, to);
        collect(0, id, res, t1, to, st, bc, e);
        n_cmp++; if (to || res !== 32'd0 || id !== e.id) begin n_bad++; $display("FAIL zero_result got=%b/%h want=0/00000000", id, res); end
        n_cmp++; if (t1 - t0 != zlat) begin n_bad++; $display("FAIL zero_latency got=%0d want=%0d", t1 - t0, zlat); end
        n_cmp++; if (mul_a !== 32'd0 || mul_b !== 32'd9) begin n_bad++; $display("FAIL zero_mul_ab got=%h/%h want=0/9", mul_a, mul_b); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] gnt; int t0, t1, bc; bit to, st, seen; logic id; logic [31:0] res; exp_t e;
        issue(2'b01, 32'd3, 32'd3, 32'd0, 32'd0, gnt, t0, to);
        collect(0, id, res, t1, to, st, bc, e);
        issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd0, gnt, t0, to);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        #1;
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_status got=busy %b valid %b want=0 0", busy, resp_valid); end
        n_cmp++; if (mul_a !== 32'd0 || resp_result !== 32'd0) begin n_bad++; $display("FAIL rmid_regs got=%h/%h want=0/0", mul_a, resp_result); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resp got=%b want=0", seen); end
        issue(2'b11, 32'd10, 32'd11, 32'd12, 32'd13, gnt, t0, to);
        n_cmp++; if (to || gnt !== 2'b01) begin n_bad++; $display("FAIL rmid_rr got=%b want=01", gnt); end
        collect(0, id, res, t1, to, st, bc, e);
        n_cmp++; if (to || id !== e.id || res !== e.res) begin n_bad++; $display("FAIL rmid_sb0 got=%b/%h want=%b/%h", id, res, e.id, e.res); end
        issue(2'b10, 32'd0, 32'd0, 32'd7, 32'd8, gnt, t0, to);
        collect(0, id, res, t1, to, st, bc, e);
        n_cmp++; if (to || id !== 1'b1 || res !== 32'd56 || res !== e.res) begin n_bad++; $display("FAIL rmid_port1 got=%b/%h want=1/38", id, res); end
        n_cmp++; if (t1 - t0 != 5) begin n_bad++; $display("FAIL rmid_latency got=%0d want=5", t1 - t0); end
    endtask

    task automatic test_latency1();
        int t0, t1; bit to; exp_t e;
        @(negedge clk);
        l_req_valid = 2'b01; l_a0 = 32'h0000_FFFF; l_b0 = 32'h0000_FFFF;
        #1;
        n_cmp++; if (l_req_ready !== 2'b01) begin n_bad++; $display("FAIL l1_grant got=%b want=01", l_req_ready); end
        t0 = cyc;
        e.id = 1'b0; e.res = l_a0 * l_b0;
        sbq.push_back(e);
        @(negedge clk);
        l_req_valid = 2'b00;
        #1;
        to = 1'b1; t1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (l_resp_valid) begin to = 1'b0; t1 = cyc; break; end
            @(negedge clk); #1;
        end
        e = sbq.pop_front();
        n_cmp++; if (to || t1 - t0 != 2) begin n_bad++; $display("FAIL l1_latency got=%0d timeout=%0d want=2", t1 - t0, to); end
        n_cmp++; if (l_resp_result !== 32'hFFFE_0001 || l_resp_result !== e.res || l_resp_id !== e.id) begin n_bad++; $display("FAIL l1_result got=%h want=fffe0001", l_resp_result); end
        l_resp_ready = 1'b1;
        @(negedge clk);
        l_resp_ready = 1'b0;
        #1;
        n_cmp++; if (l_busy !== 1'b0) begin n_bad++; $display("FAIL l1_busy_after got=%b want=0", l_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_overflow();
        test_reset_mid();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Multicycle controller and two-port arbiter for the shared combinational 32x32 Booth multiplier (low 32 product bits).
- Accepts multiply requests from two requesters (port 0: integer pipeline; port 1: address/debug unit) and grants them round-robin.
- Holds the granted operands stable on the multiplier inputs for LATENCY cycles, so the multiplier is timed as a multicycle path.
- Captures the product and returns it with the requester ID over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand and result width; must match the multiplier.
- LATENCY, 4, cycles the operands are held before the product is sampled; legal range 1..15.
- CW, 4, width of the latency counter; must satisfy 2^CW > LATENCY.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  2  request valid, one bit per requester
- req_ready  output  2  request accepted this cycle, one-hot or zero
- req_a0  input  WIDTH  operand A, requester 0
- req_b0  input  WIDTH  operand B, requester 0
- req_a1  input  WIDTH  operand A, requester 1
- req_b1  input  WIDTH  operand B, requester 1
- mul_a  output  WIDTH  registered operand A to the shared multiplier
- mul_b  output  WIDTH  registered operand B to the shared multiplier
- mul_result  input  WIDTH  product from the shared multiplier
- resp_valid  output  1  result available
- resp_id  output  1  requester that owns the result
- resp_result  output  WIDTH  registered product
- resp_ready  input  1  consumer takes the result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - mul_a, mul_b, resp_result = 0.
  - resp_valid = 0, resp_id = 0, busy = 0.
  - Round-robin pointer rr = 0, meaning requester 0 is preferred.
  - Counter = 0.
  - Reset wins over every other event, including mid-RUN and mid-DONE; any in-flight result is discarded with no response.
- State machine (IDLE, RUN, DONE):
  - IDLE:
    - Grant is combinational: if only one req_valid bit is set, grant it. If both are set, grant requester rr.
    - req_ready is high for the granted port only, and only in IDLE.
    - On the handshake, latch that port's A/B into mul_a/mul_b and record grant into resp_id.
    - Set counter = LATENCY-1 and go to RUN.
    - With no req_valid, stay in IDLE.
  - RUN:
    - mul_a and mul_b are held constant.
    - If counter != 0, decrement.
    - If counter == 0, latch resp_result <= mul_result and go to DONE.
  - DONE:
    - resp_valid = 1; resp_id and resp_result are stable.
    - On resp_ready, go to IDLE and set rr <= ~resp_id.
    - Without resp_ready, hold indefinitely (backpressure).
- Latency: with the handshake in cycle T, resp_valid is first high in cycle T+LATENCY+1. With LATENCY=1, RUN lasts exactly one cycle.
- Throughput: at most one request per LATENCY+2 cycles. No request is accepted in RUN or DONE; req_ready = 0 there.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1.
- Request inputs are not sampled outside the IDLE handshake. A requester may change operands while not granted.
- Product arithmetic belongs to the multiplier. The arbiter passes bits unmodified: two's-complement low WIDTH bits, overflow silently truncated.
- mul_a and mul_b keep the last operands after DONE. They are not cleared.

Optional Feature:
- Macro: MUL_ARB_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted req_a or req_b is 0, skip RUN.
  - Go directly to DONE with resp_result <= 0 and resp_id recorded.
  - resp_valid is high in cycle T+1.
  - mul_a/mul_b are still loaded with the operands.
- Undefined: zero operands take the full LATENCY path like any other operands.

Test Plan:
- Reset, then a single request: req_valid=01, a0=7, b0=6 in cycle T. Expect req_ready=01 in T; resp_valid=1, resp_id=0, resp_result=42 (0x2A) in cycle T+5; busy high T+1..T+5.
- Signed product with backpressure: port1 sends a1=0xFFFFFFFD (-3), b1=5, and resp_ready is held low 3 cycles. Expect resp_result=0xFFFFFFF1 and resp_id=1 stable throughout; req_ready=00 until the response handshake completes.
- Contention: req_valid=11 held for 4 transactions with a0=2,b0=3 and a1=4,b1=5. Expect grant order 0,1,0,1 and results 6,20,6,20; each req_ready is one-hot.
- Overflow truncation: a0=0x80000000, b0=2. Expect resp_result=0x00000000 after the full LATENCY. With MUL_ARB_ZERO_BYPASS_EN, a0=0, b0=9 gives resp_valid at T+1 with result 0.
- Reset mid-operation: assert rst in the second RUN cycle. Next cycle expect busy=0, resp_valid=0, mul_a=0, rr=0, and no response ever issued. A fresh request from port 1 then completes normally.
- LATENCY=1 build: a0=0x0000FFFF, b0=0x0000FFFF. Expect resp_result=0xFFFE0001 in cycle T+2.
